// File: rtl/sram_device_model_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_device_model_if
//  Purpose  : Control and address pins of the 16-bit asynchronous
//             cellular-RAM interface. The controller drives them through the
//             master modport. The device model samples them through the
//             slave modport.
//  Signals  : sram_ce   chip enable, active-low
//             sram_oe   output enable, active-low
//             sram_we   write enable, active-low (overrides sram_oe)
//             sram_lb   lower byte lane enable, active-low
//             sram_ub   upper byte lane enable, active-low
//             sram_cre  configuration-register enable (must stay 0)
//             sram_addr halfword address [23:1]
//  Note     : The bidirectional data bus is a separate inout port so that
//             its tristate drivers resolve on a plain net.
//  Revision : 1.0 - initial release
// ============================================================================
interface sram_device_model_if;
  logic        sram_ce;
  logic        sram_oe;
  logic        sram_we;
  logic        sram_lb;
  logic        sram_ub;
  logic        sram_cre;
  logic [23:1] sram_addr;

  modport master (
    output sram_ce, sram_oe, sram_we, sram_lb, sram_ub, sram_cre, sram_addr
  );

  modport slave (
    input  sram_ce, sram_oe, sram_we, sram_lb, sram_ub, sram_cre, sram_addr
  );
endinterface
`default_nettype wire

// File: rtl/sram_device_model.sv
`default_nettype none
// ============================================================================
//  Module   : sram_device_model
//  Purpose  : Clocked stand-in for a 16-bit asynchronous cellular RAM.
//             It samples the controller's pins on every rising edge and
//             serves reads from an internal halfword array. It commits write
//             windows, enforces the programmed read and write timing, and
//             flags protocol violations.
//  Ports    : clk        system clock
//             rst        asynchronous reset, active-low
//             bus        control/address pins (slave modport)
//             sram_data  16-bit bidirectional data bus
//             rd_valid   settled read data is on sram_data
//             wr_commits count of committed writes (wraps)
//             timing_err sticky protocol-violation flag
//             err_clr    synchronous clear for timing_err
//  Revision : 1.0 - initial release
// ============================================================================
module sram_device_model #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  sram_device_model_if.slave  bus,
  inout  wire  [15:0]         sram_data,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    wr_commits,
  output logic                timing_err,
  input  logic                err_clr
);

  localparam logic [2:0] c_rd_lat = 3'(RD_LAT);
  localparam logic [2:0] c_wr_lat = 3'(WR_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [23:1]        r_addr;
  logic               r_ce;
  logic               r_we;
  logic               r_lb;
  logic               r_ub;
  logic [2:0]         r_stab;
  logic [2:0]         r_wlen;
  logic [15:0]        r_hold_data;
  logic               r_hold_lb;
  logic               r_hold_ub;
  logic [CNT_W-1:0]   r_commits;
  logic               r_err;
  logic [15:0]        r_mem [2**ADDR_W];

  logic               w_addr_chg;
  logic               w_win_end;
  logic               w_commit;
  logic               w_err_set;
  logic               w_rd_ok;
  logic [ADDR_W-1:0]  w_idx;
  logic [15:0]        w_rd_data;

  // Next state is the decode of the pins about to be sampled. The window
  // bookkeeping compares that decode with the previous sample.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_addr_chg  = 1'b0;
    w_win_end   = 1'b0;
    w_commit    = 1'b0;
    w_err_set   = 1'b0;
    if (!bus.sram_ce) begin
      if (!bus.sram_we) begin
        w_state_nxt = ST_WRITE;
      end else if (!bus.sram_oe) begin
        w_state_nxt = ST_READ;
      end
    end
    w_addr_chg = (bus.sram_addr != r_addr);
    // An address change with we still low closes the window at the old address.
    w_win_end  = (r_state == ST_WRITE) && ((w_state_nxt != ST_WRITE) || w_addr_chg);
    w_commit   = w_win_end && (r_wlen >= c_wr_lat);
    w_err_set  = (w_win_end && !w_commit) || (bus.sram_cre && !bus.sram_ce);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_ce        <= 1'b1;
      r_we        <= 1'b1;
      r_lb        <= 1'b1;
      r_ub        <= 1'b1;
      r_stab      <= 3'd0;
      r_wlen      <= 3'd0;
      r_hold_data <= 16'h0000;
      r_hold_lb   <= 1'b1;
      r_hold_ub   <= 1'b1;
      r_commits   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= bus.sram_addr;
      r_ce    <= bus.sram_ce;
      r_we    <= bus.sram_we;
      r_lb    <= bus.sram_lb;
      r_ub    <= bus.sram_ub;

      // Only addr, ce and we restart the settle time. An oe or lane change
      // does not.
      if (w_addr_chg || (bus.sram_ce != r_ce) || (bus.sram_we != r_we)) begin
        r_stab <= 3'd1;
      end else if (r_stab != 3'd7) begin
        r_stab <= r_stab + 3'd1;
      end

      if (w_state_nxt == ST_WRITE) begin
        if ((r_state == ST_WRITE) && !w_addr_chg) begin
          if (r_wlen != 3'd7) begin
            r_wlen <= r_wlen + 3'd1;
          end
        end else begin
          r_wlen <= 3'd1;
        end
        r_hold_data <= sram_data;
        r_hold_lb   <= bus.sram_lb;
        r_hold_ub   <= bus.sram_ub;
      end else begin
        r_wlen <= 3'd0;
      end

      if (w_commit) begin
        r_commits <= r_commits + CNT_W'(1);
      end

      // A new violation wins over a clear on the same edge.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Array contents survive reset. While reset is held the state is IDLE,
  // so w_commit is low.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (!r_hold_lb) begin
        r_mem[r_addr[ADDR_W:1]][7:0] <= r_hold_data[7:0];
      end
      if (!r_hold_ub) begin
        r_mem[r_addr[ADDR_W:1]][15:8] <= r_hold_data[15:8];
      end
    end
  end

  // The read is combinational from the registered address, so a commit and a
  // read on the same edge return the freshly written data.
  assign w_idx     = r_addr[ADDR_W:1];
  assign w_rd_data = r_mem[w_idx];
  assign w_rd_ok   = (r_state == ST_READ) && (r_stab >= c_rd_lat);

  assign sram_data[7:0]  = (w_rd_ok && !r_lb) ? w_rd_data[7:0]  : 8'hzz;
  assign sram_data[15:8] = (w_rd_ok && !r_ub) ? w_rd_data[15:8] : 8'hzz;

  assign rd_valid   = w_rd_ok;
  assign wr_commits = r_commits;
  assign timing_err = r_err;

endmodule
`default_nettype wire

// File: doc/sram_device_model.md
Name: sram_device_model

Overview:
- Clocked responder for the 16-bit asynchronous cellular-RAM pin interface. It answers the sram_* pins that our SRAM controller drives.
- Used in simulation and in FPGA builds without external SRAM, to stand in for the physical part behind the controller.
- Backed by an internal halfword array. Enforces programmable read/write timing and flags protocol violations.

Parameters:
- ADDR_W, 12: halfword array depth is 2^ADDR_W. Indexed by sram_addr[ADDR_W:1]; upper address bits are ignored, so addresses alias.
- RD_LAT, 1: clock edges the sampled address/control must stay stable before read data is driven (1..7).
- WR_LAT, 1: minimum write-window length in cycles for a commit (1..7).
- CNT_W, 16: width of the commit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- sram_ce  in  1  chip enable, active-low
- sram_oe  in  1  output enable, active-low
- sram_we  in  1  write enable, active-low; overrides oe
- sram_lb  in  1  lower byte lane enable, active-low
- sram_ub  in  1  upper byte lane enable, active-low
- sram_cre  in  1  config-register enable; must be 0
- sram_addr  in  23 [23:1]  halfword address
- sram_data  inout  16  data bus
- rd_valid  out  1  settled read data is on sram_data
- wr_commits  out  CNT_W  number of committed writes, wraps
- timing_err  out  1  sticky protocol-violation flag
- err_clr  in  1  synchronous clear for timing_err

Behaviour:
- Reset (rst=0, async): sram_data driven Z, rd_valid=0, wr_commits=0, timing_err=0, stab_cnt=0. Any open write window is discarded, not committed. Array contents are not reset.
- Sampling: on every posedge, register sram_addr, ce, we, oe, lb, ub, cre and sram_data.
- Stability counter stab_cnt: 3 bits, saturating at 7.
  - Set to 1 when the sampled addr, ce or we differs from the previous sample.
  - Otherwise incremented.
- States: IDLE, READ, WRITE, decoded from the sampled controls.
  - IDLE: ce=1.
  - READ: ce=0, we=1, oe=0.
  - WRITE: ce=0, we=0.
  - ce=0, we=1, oe=1 is IDLE with the bus undriven.
- READ:
  - When stab_cnt >= RD_LAT, drive mem[sampled addr] with rd_valid=1.
  - Lanes with lb=1 or ub=1 stay Z.
  - Before that point, the bus is Z and rd_valid=0.
  - Pin changes take effect at the next posedge (registered view).
- WRITE window:
  - Each cycle in WRITE captures the sampled data and lane enables into a holding register.
  - Window length counter wlen saturates at 7.
  - The bus is never driven in WRITE.
- Commit: happens on the edge where the window ends. A window ends when the sampled we=1, ce=1, or the address changes while we stays 0.
  - If wlen >= WR_LAT, write the holding data to the old address on enabled lanes only, and increment wr_commits.
  - Otherwise no array write and timing_err is set.
  - An address change with we held low commits the old window and opens a new one at the new address in the same edge.
- Commit/read same edge: when a commit and a READ of the same address fall on the same edge, the read returns the newly committed data (write-first).
- Errors:
  - timing_err is also set when the sampled cre=1 with ce=0.
  - err_clr=1 clears timing_err on the next edge.
  - If a new error occurs on the same edge as err_clr, the error wins.
- Controller compatibility: the defaults satisfy the controller's 2-cycle read capture and its 1-cycle write pulses.

Test Plan:
- Reset: hold rst=0 with pins toggling -> sram_data=Z, rd_valid=0, wr_commits=0, timing_err=0. Release, keep ce=1 -> still Z.
- Write then read: addr 0x000004, data 16'hBEEF, lb=ub=0, we low for 2 cycles then high -> wr_commits=1. Then oe=0, we=1 -> after 1 edge sram_data=16'hBEEF, rd_valid=1.
- Byte lane: write 16'h1234 to 0x000004 with ub=1, lb=0 -> array holds 16'hBE34. Read with ub=1 -> sram_data[15:8]=Z, [7:0]=8'h34.
- Back-to-back address: we held low for 1 cycle at 0x10 (16'hAAAA), then 1 cycle at 0x11 (16'h5555), then we=1 -> wr_commits +2, readback 16'hAAAA and 16'h5555.
- Violations (WR_LAT=2, RD_LAT=3):
  - 1-cycle we pulse -> no commit, timing_err=1.
  - Read after an address change -> rd_valid rises exactly on the 3rd edge.
  - err_clr -> timing_err=0.
  - cre=1 with ce=0 -> timing_err=1.
  - rst=0 during a 2-cycle write -> no commit.
- End-to-end with the SRAM controller: 32-bit write of 32'hCAFEF00D to byte address 0x40, then read -> controller dout=32'hCAFEF00D, timing_err=0.
